// File: rtl/clarvi_mem_arbiter.sv
// clarvi_mem_arbiter: shares one 64-bit word-addressed memory port between
// instruction fetch (read-only) and data load/store. Holds the grant while the
// memory stalls, and tracks the owner of every outstanding read so responses
// are routed back in order.
// Optional feature: define CLARVI_MEM_ARB_ROUND_ROBIN_EN to alternate priority
// on simultaneous requests; otherwise data always wins over fetch.
module clarvi_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned MAX_PENDING = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic                  i_read,
  output logic                  i_waitrequest,
  output logic                  i_readdatavalid,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [7:0]            d_byteenable,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [63:0]           d_writedata,
  output logic                  d_waitrequest,
  output logic                  d_readdatavalid,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [7:0]            mem_byteenable,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [63:0]           mem_writedata,
  input  logic                  mem_waitrequest,
  input  logic                  mem_readdatavalid,
  input  logic [63:0]           mem_readdata,
  output logic                  resp_orphan
);

  localparam int unsigned PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);

  typedef enum logic [1:0] {StIdle, StLockI, StLockD} state_e;

  state_e                 state_q, state_d;
  logic [MAX_PENDING-1:0] owner_q;
  logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic                   resp_orphan_q;

  logic fifo_full, fifo_empty;
  logic d_elig, i_elig;
  logic grant_i, grant_d, accept;
  logic push, pop, head_owner, orphan_hit;
  logic prefer_d;

  // Read data goes straight to the consumers; the arbiter only routes valids.
  logic unused_readdata;
  assign unused_readdata = ^mem_readdata;

  assign fifo_full  = (count_q == CNT_W'(MAX_PENDING));
  assign fifo_empty = (count_q == '0);

  // A full owner FIFO blocks reads but never writes.
  assign d_elig = d_write | (d_read & ~fifo_full);
  assign i_elig = i_read & ~fifo_full;

`ifdef CLARVI_MEM_ARB_ROUND_ROBIN_EN
  logic last_d_q;

  // Remember who won the last accepted command; resets to fetch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_d_q <= 1'b0;
    end else if (accept) begin
      last_d_q <= grant_d;
    end
  end

  assign prefer_d = ~last_d_q;
`else
  assign prefer_d = 1'b1;
`endif

  // Grant selection and lock state transitions; reset forces no grant.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    state_d = state_q;
    if (reset) begin
      case (state_q)
        StIdle: begin
          if (d_elig && (prefer_d || !i_elig)) begin
            grant_d = 1'b1;
          end else if (i_elig) begin
            grant_i = 1'b1;
          end
        end
        StLockI: grant_i = i_read;
        StLockD: grant_d = d_read | d_write;
        default: ;
      endcase
      if (grant_d) begin
        state_d = mem_waitrequest ? StLockD : StIdle;
      end else if (grant_i) begin
        state_d = mem_waitrequest ? StLockI : StIdle;
      end else begin
        state_d = StIdle;
      end
    end
  end

  // Lock state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory command mux; d_read with d_write is treated as a write.
  always_comb begin
    mem_address     = grant_d ? d_address : i_address;
    mem_byteenable  = grant_d ? d_byteenable : 8'hFF;
    mem_writedata   = d_writedata;
    mem_write       = grant_d & d_write;
    mem_read        = grant_i | (grant_d & ~d_write);
    i_waitrequest   = ~(grant_i & ~mem_waitrequest);
    d_waitrequest   = ~(grant_d & ~mem_waitrequest);
  end

  assign accept     = (grant_i | grant_d) & ~mem_waitrequest;
  assign push       = accept & mem_read;
  assign pop        = reset & mem_readdatavalid & ~fifo_empty;
  assign orphan_hit = mem_readdatavalid & fifo_empty;
  assign head_owner = owner_q[rd_ptr_q];

  // Response routing by the owner at the FIFO head.
  always_comb begin
    i_readdatavalid = pop & ~head_owner;
    d_readdatavalid = pop & head_owner;
  end

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_PENDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Owner FIFO (1 = data) plus the sticky orphan-response flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      resp_orphan_q <= 1'b0;
    end else begin
      if (push) begin
        owner_q[wr_ptr_q] <= grant_d;
        wr_ptr_q          <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (orphan_hit) begin
        resp_orphan_q <= 1'b1;
      end
    end
  end

  assign resp_orphan = resp_orphan_q;

endmodule

// File: tb/tb_clarvi_mem_arbiter.sv
// Directed testbench for clarvi_mem_arbiter (ADDR_WIDTH=14, MAX_PENDING=2).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_clarvi_mem_arbiter;

  logic        clock;
  logic        reset;
  logic [13:0] i_address;
  logic        i_read;
  logic        i_waitrequest;
  logic        i_readdatavalid;
  logic [13:0] d_address;
  logic [7:0]  d_byteenable;
  logic        d_read;
  logic        d_write;
  logic [63:0] d_writedata;
  logic        d_waitrequest;
  logic        d_readdatavalid;
  logic [13:0] mem_address;
  logic [7:0]  mem_byteenable;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_writedata;
  logic        mem_waitrequest;
  logic        mem_readdatavalid;
  logic [63:0] mem_readdata;
  logic        resp_orphan;

  int checks = 0;
  int errors = 0;

  clarvi_mem_arbiter dut (
    .clock             (clock),
    .reset             (reset),
    .i_address         (i_address),
    .i_read            (i_read),
    .i_waitrequest     (i_waitrequest),
    .i_readdatavalid   (i_readdatavalid),
    .d_address         (d_address),
    .d_byteenable      (d_byteenable),
    .d_read            (d_read),
    .d_write           (d_write),
    .d_writedata       (d_writedata),
    .d_waitrequest     (d_waitrequest),
    .d_readdatavalid   (d_readdatavalid),
    .mem_address       (mem_address),
    .mem_byteenable    (mem_byteenable),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_writedata     (mem_writedata),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdatavalid (mem_readdatavalid),
    .mem_readdata      (mem_readdata),
    .resp_orphan       (resp_orphan)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // The data requester must never issue read and write together.
  always @(posedge clock) begin
    assert (!(d_read && d_write)) else $error("FAIL illegal_rw: d_read and d_write both high");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    i_read            = 1'b0;
    d_read            = 1'b0;
    d_write           = 1'b0;
    mem_waitrequest   = 1'b0;
    mem_readdatavalid = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    i_address    = 14'h0;
    d_address    = 14'h0;
    d_byteenable = 8'h00;
    d_writedata  = 64'h0;
    mem_readdata = 64'h0;
    idle_inputs();
    // Requests and a response present during reset must not leak through.
    i_read            = 1'b1;
    mem_readdatavalid = 1'b1;
    #1;
    check("rst_i_wait", i_waitrequest, 1);
    check("rst_d_wait", d_waitrequest, 1);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_i_rdv", i_readdatavalid, 0);
    check("rst_d_rdv", d_readdatavalid, 0);
    check("rst_orphan", resp_orphan, 0);
    @(negedge clock);
    idle_inputs();
    @(negedge clock);
    reset = 1'b1;

    // 1: fetch-only read, response two cycles later
    @(negedge clock);
    i_read = 1'b1; i_address = 14'h010;
    #1;
    check("t1_i_wait", i_waitrequest, 0);
    check("t1_mem_read", mem_read, 1);
    check("t1_addr", mem_address, 14'h010);
    check("t1_be", mem_byteenable, 8'hFF);
    check("t1_d_wait", d_waitrequest, 1);
    @(negedge clock);
    i_read = 1'b0;
    #1;
    check("t1_i_wait_idle", i_waitrequest, 1);
    check("t1_mem_read_idle", mem_read, 0);
    @(negedge clock);
    mem_readdatavalid = 1'b1; mem_readdata = 64'hDEADBEEF_00000001;
    #1;
    check("t1_i_rdv", i_readdatavalid, 1);
    check("t1_d_rdv", d_readdatavalid, 0);
    @(negedge clock);
    mem_readdatavalid = 1'b0;
    #1;
    check("t1_i_rdv_once", i_readdatavalid, 0);
    check("t1_orphan", resp_orphan, 0);

    // 2: fetch read vs data write; data wins (last acceptance was fetch)
    @(negedge clock);
    i_read = 1'b1; i_address = 14'h011;
    d_write = 1'b1; d_address = 14'h020; d_byteenable = 8'h0F;
    d_writedata = 64'h1122334455667788;
    #1;
    check("t2_d_wait", d_waitrequest, 0);
    check("t2_i_wait", i_waitrequest, 1);
    check("t2_mem_write", mem_write, 1);
    check("t2_mem_read", mem_read, 0);
    check("t2_addr", mem_address, 14'h020);
    check("t2_be", mem_byteenable, 8'h0F);
    check("t2_wdata", mem_writedata, 64'h1122334455667788);
    @(negedge clock);
    d_write = 1'b0;
    #1;
    check("t2_i_wait_next", i_waitrequest, 0);
    check("t2_addr_next", mem_address, 14'h011);
    @(negedge clock);
    i_read = 1'b0;
    mem_readdatavalid = 1'b1;
    #1;
    check("t2_i_rdv", i_readdatavalid, 1);
    @(negedge clock);
    mem_readdatavalid = 1'b0;

    // 3: data read stalled 3 cycles while fetch also requests
    @(negedge clock);
    d_read = 1'b1; d_address = 14'h030;
    i_read = 1'b1; i_address = 14'h012;
    mem_waitrequest = 1'b1;
    #1;
    check("t3_addr0", mem_address, 14'h030);
    check("t3_d_wait0", d_waitrequest, 1);
    check("t3_mem_read0", mem_read, 1);
    for (int k = 1; k < 3; k++) begin
      @(negedge clock);
      #1;
      check("t3_addr_hold", mem_address, 14'h030);
      check("t3_i_wait_hold", i_waitrequest, 1);
    end
    @(negedge clock);
    mem_waitrequest = 1'b0;
    #1;
    check("t3_d_accept", d_waitrequest, 0);
    check("t3_addr3", mem_address, 14'h030);
    check("t3_i_wait3", i_waitrequest, 1);
    @(negedge clock);
    d_read = 1'b0;
    #1;
    check("t3_i_accept", i_waitrequest, 0);
    check("t3_i_addr", mem_address, 14'h012);
    @(negedge clock);
    i_read = 1'b0;
    mem_readdatavalid = 1'b1;
    #1;
    check("t3_rsp0_d", d_readdatavalid, 1);
    check("t3_rsp0_i", i_readdatavalid, 0);
    @(negedge clock);
    #1;
    check("t3_rsp1_i", i_readdatavalid, 1);
    check("t3_rsp1_d", d_readdatavalid, 0);
    @(negedge clock);
    mem_readdatavalid = 1'b0;

    // 3b: a stalled fetch keeps the port even when data arrives
    @(negedge clock);
    i_read = 1'b1; i_address = 14'h013;
    mem_waitrequest = 1'b1;
    #1;
    check("t3b_addr0", mem_address, 14'h013);
    @(negedge clock);
    d_write = 1'b1; d_address = 14'h021; d_byteenable = 8'hF0;
    #1;
    check("t3b_lock_addr", mem_address, 14'h013);
    check("t3b_lock_write", mem_write, 0);
    check("t3b_d_wait", d_waitrequest, 1);
    @(negedge clock);
    mem_waitrequest = 1'b0;
    #1;
    check("t3b_i_accept", i_waitrequest, 0);
    check("t3b_d_wait2", d_waitrequest, 1);
    @(negedge clock);
    i_read = 1'b0;
    #1;
    check("t3b_d_accept", d_waitrequest, 0);
    check("t3b_mem_write", mem_write, 1);
    @(negedge clock);
    d_write = 1'b0;
    mem_readdatavalid = 1'b1;
    #1;
    check("t3b_i_rdv", i_readdatavalid, 1);
    @(negedge clock);
    mem_readdatavalid = 1'b0;

    // 4: owner FIFO full blocks reads, not writes; no same-cycle bypass
    @(negedge clock);
    d_read = 1'b1; d_address = 14'h040;
    #1;
    check("t4_d0_accept", d_waitrequest, 0);
    @(negedge clock);
    d_read = 1'b0;
    i_read = 1'b1; i_address = 14'h014;
    #1;
    check("t4_i_accept", i_waitrequest, 0);
    @(negedge clock);
    #1;
    check("t4_full_i_wait", i_waitrequest, 1);
    check("t4_full_no_read", mem_read, 0);
    @(negedge clock);
    i_read = 1'b0;
    d_write = 1'b1; d_address = 14'h022; d_byteenable = 8'hFF;
    #1;
    check("t4_full_write", d_waitrequest, 0);
    check("t4_full_mem_write", mem_write, 1);
    @(negedge clock);
    d_write = 1'b0;
    d_read = 1'b1; d_address = 14'h041;
    #1;
    check("t4_full_d_wait", d_waitrequest, 1);
    @(negedge clock);
    mem_readdatavalid = 1'b1;
    #1;
    check("t4_rsp_d", d_readdatavalid, 1);
    check("t4_no_bypass", d_waitrequest, 1);
    @(negedge clock);
    mem_readdatavalid = 1'b0;
    #1;
    check("t4_d_accept", d_waitrequest, 0);
    check("t4_d_addr", mem_address, 14'h041);
    @(negedge clock);
    d_read = 1'b0;
    mem_readdatavalid = 1'b1;
    #1;
    check("t4_rsp_i", i_readdatavalid, 1);
    @(negedge clock);
    #1;
    check("t4_rsp_d2", d_readdatavalid, 1);
    @(negedge clock);
    mem_readdatavalid = 1'b0;

    // 2b: conflict right after a data acceptance
    @(negedge clock);
    i_read = 1'b1; i_address = 14'h016;
    d_write = 1'b1; d_address = 14'h023;
    #1;
`ifdef CLARVI_MEM_ARB_ROUND_ROBIN_EN
    check("t2b_i_first", i_waitrequest, 0);
    check("t2b_d_waits", d_waitrequest, 1);
    @(negedge clock);
    i_read = 1'b0;
    #1;
    check("t2b_d_second", d_waitrequest, 0);
    check("t2b_mem_write", mem_write, 1);
`else
    check("t2b_d_first", d_waitrequest, 0);
    check("t2b_i_waits", i_waitrequest, 1);
    @(negedge clock);
    d_write = 1'b0;
    #1;
    check("t2b_i_second", i_waitrequest, 0);
    check("t2b_mem_read", mem_read, 1);
`endif
    @(negedge clock);
    idle_inputs();
    mem_readdatavalid = 1'b1;
    #1;
    check("t2b_i_rdv", i_readdatavalid, 1);
    @(negedge clock);
    mem_readdatavalid = 1'b0;

    // 5: response with nothing pending
    @(negedge clock);
    mem_readdatavalid = 1'b1;
    #1;
    check("t5_no_i_rdv", i_readdatavalid, 0);
    check("t5_no_d_rdv", d_readdatavalid, 0);
    @(negedge clock);
    mem_readdatavalid = 1'b0;
    #1;
    check("t5_orphan_set", resp_orphan, 1);
    @(negedge clock);
    #1;
    check("t5_orphan_sticky", resp_orphan, 1);

    // 6: reset with two reads outstanding
    @(negedge clock);
    d_read = 1'b1; d_address = 14'h050;
    @(negedge clock);
    d_read = 1'b0;
    i_read = 1'b1; i_address = 14'h017;
    #1;
    check("t6_i_accept", i_waitrequest, 0);
    @(negedge clock);
    reset = 1'b0;
    mem_readdatavalid = 1'b1;
    #1;
    check("t6_rst_i_wait", i_waitrequest, 1);
    check("t6_rst_d_wait", d_waitrequest, 1);
    check("t6_rst_mem_read", mem_read, 0);
    check("t6_rst_i_rdv", i_readdatavalid, 0);
    check("t6_rst_d_rdv", d_readdatavalid, 0);
    check("t6_rst_orphan", resp_orphan, 0);
    @(negedge clock);
    reset = 1'b1;
    i_read = 1'b0;
    #1;
    check("t6_late_d_rdv", d_readdatavalid, 0);
    check("t6_late_i_rdv", i_readdatavalid, 0);
    @(negedge clock);
    mem_readdatavalid = 1'b0;
    #1;
    check("t6_orphan", resp_orphan, 1);
    @(negedge clock);
    i_read = 1'b1; i_address = 14'h018;
    #1;
    check("t6_new_accept", i_waitrequest, 0);
    check("t6_new_addr", mem_address, 14'h018);
    @(negedge clock);
    i_read = 1'b0;
    mem_readdatavalid = 1'b1;
    #1;
    check("t6_new_rdv", i_readdatavalid, 1);
    @(negedge clock);
    idle_inputs();
    #1;
    check("t6_rdv_clear", i_readdatavalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
